// File: rtl/keypad_scan_if.sv
// Keypad pin bundle: active-low row sense lines in, active-low column drive
// and the decoded key/press status out.
interface keypad_scan_if;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key;
   logic       pressed;
   logic       key_valid;

   modport master (input row, output col, key, pressed, key_valid);
   modport slave  (output row, input col, key, pressed, key_valid);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks the columns, debounces one latched key
// through press and release, and reports its hex code.
module keypad_scan #(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic          clk,
   input  logic          rst,
   keypad_scan_if.master kp
);
   typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_e;

   localparam logic [15:0] SLOT_LAST = 16'(SCAN_DIV - 1);
   localparam logic [19:0] DEB_N     = 20'(DEBOUNCE_CYCLES);

   state_e      state_q, state_d;
   logic [3:0]  rs1_q, rs1_d, rs_q, rs_d;
   logic [15:0] slot_q, slot_d;
   logic [19:0] cnt_q, cnt_d;
   logic [1:0]  c_q, c_d, r_q, r_d;
   logic [3:0]  key_q, key_d;
   logic        pressed_q, pressed_d, kv_q, kv_d;

   logic        slot_end, hit, trk_low, cnt_done;
   logic [1:0]  hit_row;

   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
         4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
         4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
         4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
      endcase
      return k;
   endfunction

   assign slot_end = (slot_q == SLOT_LAST);
   assign hit      = ~&rs_q;
   assign trk_low  = ~rs_q[r_q];
   assign cnt_done = ((cnt_q + 20'd1) == DEB_N);

   // Lowest-index low row wins when several rows are pulled down together.
   always_comb begin
      hit_row = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (!rs_q[i]) hit_row = 2'(i);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= SCAN;
         rs1_q     <= '0;
         rs_q      <= '0;
         slot_q    <= '0;
         cnt_q     <= '0;
         c_q       <= '0;
         r_q       <= '0;
         key_q     <= '0;
         pressed_q <= 1'b0;
         kv_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         rs1_q     <= rs1_d;
         rs_q      <= rs_d;
         slot_q    <= slot_d;
         cnt_q     <= cnt_d;
         c_q       <= c_d;
         r_q       <= r_d;
         key_q     <= key_d;
         pressed_q <= pressed_d;
         kv_q      <= kv_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SCAN:      if (slot_end && hit) state_d = DEB_PRESS;
         DEB_PRESS: if (!trk_low) state_d = SCAN;
                    else if (cnt_done) state_d = HELD;
         HELD:      if (!trk_low) state_d = (DEB_N == 20'd1) ? SCAN : DEB_REL;
         DEB_REL:   if (trk_low) state_d = HELD;
                    else if (cnt_done) state_d = SCAN;
         default:   state_d = SCAN;
      endcase
   end

   always_comb begin
      rs1_d     = kp.row;
      rs_d      = rs1_q;
      slot_d    = slot_q;
      cnt_d     = cnt_q;
      c_d       = c_q;
      r_d       = r_q;
      key_d     = key_q;
      pressed_d = pressed_q;
      kv_d      = 1'b0;
      case (state_q)
         SCAN: begin
            slot_d = slot_end ? 16'd0 : slot_q + 16'd1;
            if (slot_end) begin
               if (hit) begin
                  r_d   = hit_row;
                  cnt_d = '0;
               end else begin
                  c_d = c_q + 2'd1;
               end
            end
         end
         DEB_PRESS: begin
            if (!trk_low) begin
               cnt_d  = '0;
               c_d    = c_q + 2'd1;
               slot_d = '0;
            end else if (cnt_done) begin
               key_d     = key_code(r_q, c_q);
               pressed_d = 1'b1;
               kv_d      = 1'b1;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + 20'd1;
            end
         end
         HELD: begin
            // The first high sample already counts toward the release run.
            if (!trk_low) begin
               if (DEB_N == 20'd1) begin
                  pressed_d = 1'b0;
                  c_d       = c_q + 2'd1;
                  slot_d    = '0;
                  cnt_d     = '0;
               end else begin
                  cnt_d = 20'd1;
               end
            end
         end
         DEB_REL: begin
            if (trk_low) begin
               cnt_d = '0;
            end else if (cnt_done) begin
               pressed_d = 1'b0;
               c_d       = c_q + 2'd1;
               slot_d    = '0;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + 20'd1;
            end
         end
         default: ;
      endcase
      kp.col = ~(4'b0001 << c_q);
   end

   assign kp.key       = key_q;
   assign kp.pressed   = pressed_q;
   assign kp.key_valid = kv_q;
endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a switch-matrix keypad model drives the rows, and a
// run-length reference model of the scanner is compared every cycle.
module tb_keypad_scan;
   localparam int SD = 4;
   localparam int DB = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   keypad_scan_if kif();

   keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
      .clk (clk),
      .rst (rst),
      .kp  (kif.master)
   );

   // Closed switches: bit r*4+c; a row reads low when a closed switch sits on a driven column.
   logic [15:0] keymat = '0;
   logic [3:0]  rowv;
   always_comb begin
      rowv = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keymat[r*4+c] && !kif.col[c]) rowv[r] = 1'b0;
   end
   assign kif.row = rowv;

   logic [3:0] code_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

   // Reference model: scanning vs tracking a key; a tracked key is either
   // accumulating a low run (press) or a high run (release).
   logic [3:0] m_s1 = '0, m_s2 = '0;
   int   m_c = 0, m_age = 0, m_tr = 0, m_low = 0, m_high = 0;
   bit   m_trk = 0, m_held = 0;
   logic [3:0] e_key = '0;
   bit   e_pr = 0, e_kv = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_c = 0; m_age = 0; m_trk = 0; m_held = 0;
         m_low = 0; m_high = 0; e_key = '0; e_pr = 0; e_kv = 0;
      end else begin : mdl
         logic [3:0] rs;
         rs   = m_s2;
         e_kv = 0;
         if (!m_trk) begin
            if (m_age == SD - 1) begin
               m_age = 0;
               if (rs != 4'hF) begin
                  m_tr = 0;
                  while (rs[m_tr]) m_tr++;
                  m_trk = 1; m_low = 0;
               end else m_c = (m_c + 1) % 4;
            end else m_age++;
         end else if (!m_held) begin
            if (!rs[m_tr]) begin
               m_low++;
               if (m_low == DB) begin
                  m_held = 1; m_high = 0;
                  e_key = code_tab[m_tr*4 + m_c]; e_pr = 1; e_kv = 1;
               end
            end else begin
               m_trk = 0; m_c = (m_c + 1) % 4; m_age = 0;
            end
         end else begin
            if (rs[m_tr]) begin
               m_high++;
               if (m_high == DB) begin
                  m_held = 0; m_trk = 0; e_pr = 0; m_c = (m_c + 1) % 4; m_age = 0;
               end
            end else m_high = 0;
         end
         m_s2 = m_s1;
         m_s1 = rowv;
      end
   end

   int checks = 0, errors = 0, kv_seen = 0;
   logic [3:0] ecol;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      ecol = ~(4'b0001 << m_c);
      chk("col", kif.col, ecol);
      chk("key", kif.key, e_key);
      chk("pressed", kif.pressed, e_pr);
      chk("key_valid", kif.key_valid, e_kv);
      if (kif.key_valid) kv_seen++;
   end

   task automatic tick(int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_pressed(logic v, int lim, string nm);
      int n = 0;
      while (kif.pressed !== v && n < lim) begin tick(1); n++; end
      chk(nm, kif.pressed, v);
   endtask

   logic [3:0] col_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   initial begin
      int first, n;
      logic [15:0] pat;
      tick(3);
      chk("rst_col", kif.col, 4'b1110);
      chk("rst_key", kif.key, 4'h0);
      chk("rst_pressed", kif.pressed, 1'b0);
      chk("rst_kv", kif.key_valid, 1'b0);
      rst = 1'b0;

      // Idle column walk
      for (int k = 1; k <= 20; k++) begin
         tick(1);
         if (k % 4 == 2) chk("idle_col", kif.col, col_tab[(k / 4) % 4]);
      end
      tick(40);
      chk("idle_kv", kv_seen, 0);

      // r1/c2 held from reset: detection at slot end of column 2, confirm 8 later
      rst = 1'b1; keymat = 16'h0040; tick(2); rst = 1'b0;
      kv_seen = 0; first = -1;
      for (int k = 1; k <= 60; k++) begin
         tick(1);
         if (kif.key_valid && first < 0) first = k;
      end
      chk("latency", first, 20);
      chk("held_key", kif.key, 4'h6);
      chk("held_pressed", kif.pressed, 1'b1);
      chk("held_col", kif.col, 4'b1011);
      chk("held_kv_once", kv_seen, 1);
      keymat = '0;
      wait_pressed(1'b0, 40, "rel_6");

      // r3/c2 with 3-cycle glitches
      kv_seen = 0;
      repeat (3) begin keymat = 16'h4000; tick(3); keymat = '0; tick(3); end
      keymat = 16'h4000;
      wait_pressed(1'b1, 200, "press_F");
      tick(5);
      chk("glitch_key", kif.key, 4'hF);
      chk("glitch_kv_once", kv_seen, 1);
      keymat = '0;
      wait_pressed(1'b0, 40, "rel_F");

      // E pressed, release with 5-cycle bounces
      kv_seen = 0; keymat = 16'h1000;
      wait_pressed(1'b1, 200, "press_E");
      repeat (2) begin
         keymat = '0; tick(5);
         chk("bounce_pressed", kif.pressed, 1'b1);
         keymat = 16'h1000; tick(5);
      end
      keymat = '0; tick(7);
      chk("rel_early", kif.pressed, 1'b1);
      wait_pressed(1'b0, 20, "rel_E");
      chk("rel_key_hold", kif.key, 4'hE);
      chk("rel_kv_once", kv_seen, 1);

      // r0 and r2 on c1 together
      kv_seen = 0; keymat = 16'h0202;
      wait_pressed(1'b1, 200, "press_2");
      chk("multi_key", kif.key, 4'h2);
      tick(30);
      chk("multi_key_hold", kif.key, 4'h2);
      chk("multi_kv_once", kv_seen, 1);
      keymat = '0;
      wait_pressed(1'b0, 40, "rel_2");

      // Reset 4 cycles into press debounce
      keymat = 16'h0020; n = 0;
      while (!(m_trk && !m_held) && n < 100) begin tick(1); n++; end
      chk("deb_entered", m_trk, 1'b1);
      tick(4);
      kv_seen = 0; rst = 1'b1; tick(1);
      chk("abort_col", kif.col, 4'b1110);
      chk("abort_pressed", kif.pressed, 1'b0);
      chk("abort_key", kif.key, 4'h0);
      chk("abort_kv", kif.key_valid, 1'b0);
      tick(2); keymat = '0; rst = 1'b0; tick(20);
      chk("abort_no_kv", kv_seen, 0);

      // Random presses, bounces, multi-key and resets against the model
      for (int it = 0; it < 60; it++) begin
         pat = 16'h0001 << $urandom_range(0, 15);
         if ($urandom_range(0, 3) == 0) pat |= 16'h0001 << $urandom_range(0, 15);
         n = $urandom_range(0, 12);
         for (int j = 0; j < n; j++) begin keymat = $urandom_range(0, 1) ? pat : '0; tick(1); end
         keymat = pat; tick($urandom_range(5, 80));
         if ($urandom_range(0, 9) == 0) begin rst = 1'b1; tick(2); rst = 1'b0; end
         n = $urandom_range(0, 12);
         for (int j = 0; j < n; j++) begin keymat = $urandom_range(0, 1) ? pat : '0; tick(1); end
         keymat = '0; tick($urandom_range(5, 60));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end
endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clocks each column is driven before its rows are sampled; legal range 4..65535.
REQ-002 Parameter DEBOUNCE_CYCLES, default 20000, consecutive stable synchronized samples that confirm a press or a release; legal range 1..2^20-1.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 row  input  4  keypad row lines, active-low, asynchronous to clk.
REQ-006 col  output  4  keypad column drive, active-low one-hot.
REQ-007 key  output  4  hex code of the last confirmed key.
REQ-008 pressed  output  1  high while the confirmed key is held; each new press gives exactly one rising edge.
REQ-009 key_valid  output  1  one-cycle pulse on the cycle pressed rises.

Function
REQ-010 row shall pass through a 2-flop synchronizer; all decisions shall use the synchronized value rs.
REQ-011 Key map (row r, column c -> code): r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E,0,F,D (c0..c3).
REQ-012 FSM states: SCAN, DEB_PRESS, HELD, DEB_REL.
REQ-013 SCAN: col drives column c low, all others high. After SCAN_DIV cycles in the slot, sample rs on the slot's last cycle. If no row is low, advance c (3 wraps to 0).
REQ-014 SCAN, any rs bit low at the sample: latch the lowest-index low row r and column c; enter DEB_PRESS; freeze col on c.
REQ-015 Simultaneous keys: only the latched (r,c) is tracked until release; all other rows and columns are ignored.
REQ-016 DEB_PRESS: count consecutive cycles with rs[r]=0. Any cycle with rs[r]=1 shall clear the count, advance c, and return to SCAN with no output change.
REQ-017 DEB_PRESS, count reaches DEBOUNCE_CYCLES: on that edge, key <= code(r,c), pressed <= 1, key_valid <= 1 for one cycle; enter HELD.
REQ-018 HELD: remain while rs[r]=0. First cycle with rs[r]=1 enters DEB_REL with the count at 1.
REQ-019 DEB_REL: count consecutive cycles with rs[r]=1. Any rs[r]=0 cycle returns to HELD with no new key_valid and pressed still 1.
REQ-020 DEB_REL, count reaches DEBOUNCE_CYCLES: pressed <= 0; advance c; return to SCAN with a fresh slot.
REQ-021 key shall hold its value after release until the next confirmed press.
REQ-022 pressed shall never fall other than per REQ-020 or reset; key_valid shall never assert outside REQ-017.
REQ-023 Counters: slot counter 16 bit, debounce counter 20 bit; neither shall wrap while active.
REQ-024 Latency: pressed rises exactly DEBOUNCE_CYCLES cycles after the SCAN sample edge that detected the key, given rs[r] stays low.

Reset
REQ-025 While rst=1: state=SCAN, c=0, col=4'b1110, key=4'h0, pressed=0, key_valid=0, all counters and synchronizer flops cleared.
REQ-026 rst asserted mid-debounce or mid-hold shall abort immediately to the REQ-025 values; no key_valid shall be emitted.
REQ-027 After rst falls, scanning shall restart at column 0 with a full SCAN_DIV slot.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-028 Idle, rows all high -> col cycles 1110,1101,1011,0111 every 4 clocks; pressed=0; key_valid never asserts.
REQ-029 Hold r1/c2 low indefinitely -> col freezes at 1011; key=4'h6, pressed=1 and a single key_valid 8 cycles after detection; no further pulses.
REQ-030 Press r3/c2 with 3-cycle glitches before stable low -> no output during the glitches; final key=4'hF, exactly one key_valid.
REQ-031 Release r3/c0 (key E) with 5-cycle high bounces -> pressed stays 1 through the bounces; falls after 8 stable-high cycles; no second key_valid.
REQ-032 r0 and r2 low together on c1 -> key=4'h2; r2 ignored until release.
REQ-033 rst pulsed 4 cycles into DEB_PRESS -> col=1110, pressed=0, key=0, no key_valid.
